// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// out-of-range read value and the memory index-width helper.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam int OOR_DATA = 0;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream load channel: valid/ready handshake with an end-of-image marker.
interface prog_loader_if #(parameter int DATA_W = 8);
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/prog_mem_array.sv
// Program store: DEPTH x DATA_W register file, one sync write port and one
// async read port; reads beyond DEPTH return OOR_DATA.
module prog_mem_array
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [idx_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W-1:0]         rdata
);

  localparam int IW = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately survive reset; only the write pointer is cleared.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = ({1'b0, raddr} < DEPTH_X) ? mem[raddr[IW-1:0]] : DATA_W'(OOR_DATA);

endmodule

// File: rtl/prog_loader.sv
// Program loader: fills the program store from a byte stream, holds the CPU in
// reset while loading, then serves cpu_data. Optional PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      ld,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] byte_count,
  output logic              done,
  output logic              err
);

  localparam int IW = idx_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nx;
  logic              accepted, wr_en;
  logic [DATA_W-1:0] rd_data;

  assign ld.load_ready = (state == LOAD);
  assign accepted      = ld.load_valid && (state == LOAD);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum, chk;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LOAD;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    case (state)
      LOAD: if (accepted) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        // Final beat is the checksum, never stored.
        wr_en = !ld.load_last;
        if (ld.load_last)                 state_nx = (byte_count == '0) ? ERR : CHECK;
        else if (byte_count == LAST_ADDR) state_nx = ERR;
`else
        wr_en = 1'b1;
        if (ld.load_last)                 state_nx = RUN;
        else if (byte_count == LAST_ADDR) state_nx = ERR;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK:   state_nx = (sum == chk) ? RUN : ERR;
`else
      CHECK:   state_nx = ERR;
`endif
      RUN:     if (reload) state_nx = LOAD;
      default: state_nx = state;
    endcase
  end

  // byte_count doubles as the write pointer; they always move together.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      byte_count <= '0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cpu_rst <= (state_nx == RUN);
      done    <= (state_nx == RUN);
      err     <= (state_nx == ERR);
      if (state == RUN && reload) byte_count <= '0;
      else if (wr_en)             byte_count <= byte_count + ADDR_W'(1);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sum <= '0;
      chk <= '0;
    end else begin
      if (state == RUN && reload)         sum <= '0;
      else if (wr_en)                     sum <= sum + ld.load_data;
      if (accepted && ld.load_last)       chk <= ld.load_data;
    end
`endif

  prog_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (byte_count[IW-1:0]),
    .wdata (ld.load_data),
    .raddr (cpu_addr),
    .rdata (rd_data)
  );

  assign cpu_data = (state == RUN) ? rd_data : DATA_W'(OOR_DATA);

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against an image-level reference model.
module tb_prog_loader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              reload = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_rst, done, err;
  logic [ADDR_W-1:0] byte_count;

  prog_loader_if #(.DATA_W(DATA_W)) ld();

  prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ld(ld), .reload(reload), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_rst(cpu_rst), .byte_count(byte_count),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: image progress and outcome, plus a shadow of stored bytes.
  bit         m_run, m_err, m_pend;
  int         m_cnt, m_sum, m_ck;
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];

  function automatic void m_reset();
    m_run = 0; m_err = 0; m_pend = 0; m_cnt = 0; m_sum = 0;
  endfunction

  function automatic void m_beat(input int d, input bit last);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (last) begin
      if (m_cnt == 0) m_err = 1;
      else begin m_pend = 1; m_ck = d; end
    end else begin
      m_mem[m_cnt] = d[7:0]; m_known[m_cnt] = 1;
      m_sum = (m_sum + d) % 256;
      m_cnt++;
      if (m_cnt == DEPTH) m_err = 1;
    end
`else
    m_mem[m_cnt] = d[7:0]; m_known[m_cnt] = 1;
    m_cnt++;
    if (last) m_run = 1;
    else if (m_cnt == DEPTH) m_err = 1;
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".ready"}, ld.load_ready, !m_run && !m_err && !m_pend);
    check({tag, ".cpu_rst"}, cpu_rst, m_run);
    check({tag, ".done"}, done, m_run);
    check({tag, ".err"}, err, m_err);
    check({tag, ".count"}, byte_count, m_cnt);
  endtask

  task automatic check_mem();
    for (int a = 0; a < DEPTH + 2; a++) begin
      cpu_addr = ADDR_W'(a); #1;
      if (!m_run || a >= DEPTH)  check("rd_zero", cpu_data, 0);
      else if (m_known[a])       check("rd_data", cpu_data, m_mem[a]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; #1;
    m_reset();
    check_outs("rst_async");
    @(negedge clk); rst = 1'b1;
    step();
    check_outs("rst_rel");
  endtask

  task automatic beat(input logic [7:0] d, input bit last);
    int ns = $urandom_range(0, 2);
    for (int s = 0; s < ns; s++) begin
      // Held data with valid dropped must not be written; reload is ignored here.
      ld.load_valid = 1'b0; ld.load_data = d; reload = $urandom_range(0, 1);
      step();
      reload = 1'b0;
      check_outs("stall");
    end
    ld.load_valid = 1'b1; ld.load_data = d; ld.load_last = last;
    step();
    ld.load_valid = 1'b0; ld.load_last = 1'b0;
    m_beat(d, last);
    check_outs("beat");
    if (m_pend) begin
      step();
      m_pend = 0;
      if (m_ck == m_sum) m_run = 1; else m_err = 1;
      check_outs("check");
    end
  endtask

  task automatic load_q(input logic [7:0] q[$], input bit last, input int abort_at);
    for (int i = 0; i < q.size(); i++) begin
      if (m_run || m_err) break;
      if (i == abort_at) begin do_reset(); break; end
      beat(q[i], last && (i == q.size() - 1));
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    if (m_run) begin m_run = 0; m_cnt = 0; m_sum = 0; end
    check_outs("reload");
  endtask

  task automatic rand_image(input int abort_at);
    logic [7:0] q[$];
    int         n, cs;
    bit         with_last = ($urandom_range(0, 3) != 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    n  = $urandom_range(0, DEPTH);
    cs = m_sum;
    for (int i = 0; i < n; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      cs = (cs + q[i]) % 256;
    end
    if (with_last) q.push_back(8'(($urandom_range(0, 3) == 0) ? cs + 1 : cs));
`else
    n = $urandom_range(1, DEPTH + 1);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
`endif
    load_q(q, with_last, abort_at);
  endtask

  initial begin
    logic [7:0] q[$];
    ld.load_valid = 1'b0; ld.load_data = '0; ld.load_last = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_known[a] = 0;
    m_reset();
    rst = 1'b1;
    #2;
    do_reset();
    check("rst.cpu_data", cpu_data, 0);

    // Three-byte image, last on the final beat.
    q = {8'hA9, 8'h05, 8'h3C};
    load_q(q, 1'b1, -1);
    check_mem();
    pulse_reload();

    // Single-beat image after a reload.
    q = {8'h77};
    load_q(q, 1'b1, -1);
    check_mem();
    pulse_reload();

    // Overflow: DEPTH beats without last.
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(8'h40 + i));
    load_q(q, 1'b0, -1);
    check_mem();
    pulse_reload();
    do_reset();

    // Reset after two beats of a three-byte image, then a clean load.
    q = {8'h11, 8'h22, 8'h33};
    load_q(q, 1'b1, 2);
    load_q(q, 1'b1, -1);
    check_mem();

    for (int it = 0; it < 60; it++) begin
      if (m_err) begin
        pulse_reload();
        do_reset();
      end else if (m_run || $urandom_range(0, 3) == 0) begin
        pulse_reload();
      end
      rand_image(($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1);
      check_mem();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
